// File: rtl/note_pkg.sv
`default_nettype none
// ============================================================================
// Module   : note_pkg
// Purpose  : Shared note-word field layout, end-of-song marker and the
//            playback state encoding used by the note RAM reader and writers.
// Revision : 1.0 - initial release
// ============================================================================
package note_pkg;

  // Note RAM word layout: {hold[15], note[14:9], duration[8:0]}
  localparam int WORD_W   = 16;
  localparam int HOLD_BIT = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 0;

  // A zero duration terminates the song
  localparam int END_MARKER_DUR = 0;

  // Playback sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4
  } player_state_t;

endpackage : note_pkg
`default_nettype wire

// File: rtl/note_player_beat_counter.sv
`default_nettype none
// ============================================================================
// Module   : beat_counter
// Purpose  : Counts tempo beats for the entry being played and flags the
//            beat that completes the entry's duration.
// Revision : 1.0 - initial release
// ============================================================================
module beat_counter #(
  parameter int DUR_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DUR_W-1:0] duration,
  output logic             last_beat
);

  logic [DUR_W-1:0] r_beat_cnt;
  logic [DUR_W:0]   w_next_cnt;

  // One extra bit so a full-scale duration still compares correctly
  assign w_next_cnt = {1'b0, r_beat_cnt} + {{DUR_W{1'b0}}, 1'b1};
  assign last_beat  = (w_next_cnt == {1'b0, duration});

  // Beat count for the current entry; cleared when a new entry starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat_cnt <= '0;
    end else if (clear) begin
      r_beat_cnt <= '0;
    end else if (enable) begin
      r_beat_cnt <= w_next_cnt[DUR_W-1:0];
    end
  end

endmodule : beat_counter
`default_nettype wire

// File: rtl/note_player.sv
`default_nettype none
// ============================================================================
// Module   : note_player
// Purpose  : Player-piano playback sequencer. Walks note RAM from address 0,
//            presenting each entry's note for its duration in beats, with
//            tie (hold) support, pause, rewind and end-of-song detection.
// Revision : 1.0 - initial release
// ============================================================================
module note_player
  import note_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat,
  input  logic              play,
  input  logic              rewind,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              note_start,
  output logic              done
);

  localparam logic [ADDR_W-1:0] c_last_addr = '1;
  localparam logic [DUR_W-1:0]  c_end_dur   = DUR_W'(END_MARKER_DUR);

  player_state_t     r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [DUR_W-1:0]  r_dur;
  logic [NOTE_W-1:0] r_note_out;
  logic              r_note_valid;
  logic              r_note_start;
  logic              r_done;

  logic              w_rd_hold;
  logic [NOTE_W-1:0] w_rd_note;
  logic [DUR_W-1:0]  w_rd_dur;
  logic              w_beat_en;
  logic              w_cnt_clear;
  logic              w_last_beat;

  // Field extraction from the RAM word arriving during LATCH
  assign w_rd_hold = rd_data[HOLD_BIT];
  assign w_rd_note = NOTE_W'(rd_data[NOTE_MSB:NOTE_LSB]);
  assign w_rd_dur  = DUR_W'(rd_data[DUR_MSB:DUR_LSB]);

  // Beats only count while actually playing; rewind overrides everything
  assign w_beat_en   = (r_state == ST_PLAY) && play && beat && !rewind;
  assign w_cnt_clear = rewind || (r_state == ST_LATCH);

  beat_counter #(
    .DUR_W (DUR_W)
  ) u_beat_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_cnt_clear),
    .enable    (w_beat_en),
    .duration  (r_dur),
    .last_beat (w_last_beat)
  );

  // Sequencer FSM with address and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cur_addr   <= '0;
      r_dur        <= '0;
      r_note_out   <= '0;
      r_note_valid <= 1'b0;
      r_note_start <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_note_start <= 1'b0;
      if (rewind) begin
        r_state      <= ST_IDLE;
        r_cur_addr   <= '0;
        r_note_valid <= 1'b0;
        r_done       <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (play) begin
              r_state <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            r_state <= ST_LATCH;
          end
          ST_LATCH: begin
            if (w_rd_dur == c_end_dur) begin
              r_state      <= ST_DONE;
              r_done       <= 1'b1;
              r_note_valid <= 1'b0;
            end else begin
              // A hold entry ties onto the previous note without a re-strike
              r_state      <= ST_PLAY;
              r_dur        <= w_rd_dur;
              r_note_out   <= w_rd_note;
              r_note_valid <= play;
              r_note_start <= play & ~w_rd_hold;
            end
          end
          ST_PLAY: begin
            if (!play) begin
              r_note_valid <= 1'b0;
            end else begin
              r_note_valid <= 1'b1;
              if (beat && w_last_beat) begin
                if (r_cur_addr == c_last_addr) begin
                  r_state      <= ST_DONE;
                  r_done       <= 1'b1;
                  r_note_valid <= 1'b0;
                end else begin
                  r_state    <= ST_FETCH;
                  r_cur_addr <= r_cur_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
              end
            end
          end
          ST_DONE: begin
            r_done       <= 1'b1;
            r_note_valid <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rd_addr    = r_cur_addr;
  assign note_out   = r_note_out;
  assign note_valid = r_note_valid;
  assign note_start = r_note_start;
  assign done       = r_done;

endmodule : note_player
`default_nettype wire

// File: tb/tb_note_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_player
// Purpose  : Self-checking bench for note_player. A timeline model derives
//            every cycle's expected outputs from the RAM contents and the
//            beat schedule; directed steps cover pause, rewind and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_player;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        beat = 1'b0;
  logic        play = 1'b0;
  logic        rewind = 1'b0;
  logic [6:0]  rd_addr;
  logic [15:0] rd_data;
  logic [5:0]  note_out;
  logic        note_valid;
  logic        note_start;
  logic        done;

  logic [15:0] ram [128];
  bit          beat_sch [MAXC];
  int          set_addr [MAXC];
  int          set_note [MAXC];
  bit          set_nv [MAXC];
  bit          set_start [MAXC];
  bit          set_done [MAXC];
  int          exp_addr [MAXC];
  int          exp_note [MAXC];
  int          exp_nv [MAXC];
  int          exp_start [MAXC];
  int          exp_done [MAXC];

  int checks = 0;
  int failures = 0;

  note_player #(
    .ADDR_W (7),
    .NOTE_W (6),
    .DUR_W  (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .beat       (beat),
    .play       (play),
    .rewind     (rewind),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .note_out   (note_out),
    .note_valid (note_valid),
    .note_start (note_start),
    .done       (done)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Synchronous-read note RAM
  always @(posedge clk) rd_data <= ram[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] mk(input bit h, input int n, input int d);
    logic [15:0] w;
    w = {h, 6'(n), 9'(d)};
    return w;
  endfunction

  task automatic clear_ram();
    for (int i = 0; i < 128; i++) ram[i] = 16'h0000;
  endtask

  task automatic do_reset();
    play = 1'b0; beat = 1'b0; rewind = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // Drive one cycle's inputs, then observe just after the edge that took them
  task automatic tick(input logic p, input logic b, input logic rw);
    play = p; beat = b; rewind = rw;
    @(posedge clk); #1;
    beat = 1'b0; rewind = 1'b0;
  endtask

  task automatic make_beats(input int n_cyc);
    int c;
    for (int k = 0; k < MAXC; k++) beat_sch[k] = 1'b0;
    c = int'($urandom_range(1, 4));
    while (c < n_cyc) begin
      beat_sch[c] = 1'b1;
      c = c + 4 + int'($urandom_range(0, 4));
    end
  endtask

  // Timeline model: entry i sounds from cycle t; its d-th beat at cycle n
  // moves the address at n+1 and brings the next note at n+3.
  task automatic build_model(input int n_cyc);
    int t, i, d, cnt, n;
    int m_addr, m_nv, m_note, m_done;
    for (int c = 0; c < MAXC; c++) begin
      set_addr[c] = -1; set_note[c] = -1;
      set_nv[c] = 1'b0; set_start[c] = 1'b0; set_done[c] = 1'b0;
    end
    t = 3; i = 0;
    while (t < n_cyc) begin
      d = int'(ram[i][8:0]);
      if (d == 0) begin
        set_done[t] = 1'b1;
        break;
      end
      set_nv[t]    = 1'b1;
      set_note[t]  = int'(ram[i][14:9]);
      set_start[t] = !ram[i][15];
      cnt = 0; n = t;
      while (n < n_cyc) begin
        if (beat_sch[n]) begin
          cnt++;
          if (cnt == d) break;
        end
        n++;
      end
      if (n + 1 >= n_cyc) break;
      if (i == 127) begin
        set_done[n+1] = 1'b1;
        break;
      end
      i++;
      set_addr[n+1] = i;
      t = n + 3;
    end
    m_addr = 0; m_nv = 0; m_note = 0; m_done = 0;
    for (int c = 0; c < n_cyc; c++) begin
      if (set_addr[c] >= 0) m_addr = set_addr[c];
      if (set_nv[c]) m_nv = 1;
      if (set_note[c] >= 0) m_note = set_note[c];
      if (set_done[c]) begin m_done = 1; m_nv = 0; end
      exp_addr[c]  = m_addr;
      exp_nv[c]    = m_nv;
      exp_note[c]  = m_note;
      exp_start[c] = set_start[c] ? 1 : 0;
      exp_done[c]  = m_done;
    end
  endtask

  // Run with play held high, comparing every cycle against the model
  task automatic run_song(input string name, input int n_cyc);
    build_model(n_cyc);
    for (int c = 0; c < n_cyc; c++) begin
      play = 1'b1; beat = beat_sch[c];
      @(negedge clk);
      chk($sformatf("%s c%0d rd_addr", name, c), 32'(rd_addr), 32'(exp_addr[c]));
      chk($sformatf("%s c%0d note_valid", name, c), 32'(note_valid), 32'(exp_nv[c]));
      chk($sformatf("%s c%0d note_start", name, c), 32'(note_start), 32'(exp_start[c]));
      chk($sformatf("%s c%0d note_out", name, c), 32'(note_out), 32'(exp_note[c]));
      chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(exp_done[c]));
      @(posedge clk); #1;
    end
    beat = 1'b0;
  endtask

  initial begin
    int len;
    clear_ram();
    make_beats(0);

    // Reset values
    do_reset();
    chk("reset rd_addr", 32'(rd_addr), 32'd0);
    chk("reset note_out", 32'(note_out), 32'd0);
    chk("reset note_valid", 32'(note_valid), 32'd0);
    chk("reset note_start", 32'(note_start), 32'd0);
    chk("reset done", 32'(done), 32'd0);

    // Single note then end marker
    clear_ram();
    ram[0] = mk(0, 12, 3);
    ram[1] = 16'h0000;
    do_reset();
    make_beats(60);
    run_song("single", 60);

    // Tie: one strike, continuous sound across the entry gap
    clear_ram();
    ram[0] = mk(0, 5, 2);
    ram[1] = mk(1, 5, 1);
    ram[2] = 16'h0000;
    do_reset();
    make_beats(80);
    run_song("tie", 80);

    // Pause after 2 beats, 10 ignored beats, then resume
    clear_ram();
    ram[0] = mk(0, 7, 4);
    do_reset();
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    chk("pause first note_valid", 32'(note_valid), 32'd1);
    chk("pause first note_start", 32'(note_start), 32'd1);
    chk("pause first note_out", 32'(note_out), 32'd7);
    for (int b = 0; b < 2; b++) begin
      tick(1, 1, 0); tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    end
    chk("pause pre rd_addr", 32'(rd_addr), 32'd0);
    tick(0, 0, 0);
    chk("pause note_valid", 32'(note_valid), 32'd0);
    chk("pause note_out held", 32'(note_out), 32'd7);
    for (int b = 0; b < 10; b++) begin
      tick(0, 1, 0);
      chk($sformatf("paused b%0d note_valid", b), 32'(note_valid), 32'd0);
      chk($sformatf("paused b%0d note_start", b), 32'(note_start), 32'd0);
      chk($sformatf("paused b%0d rd_addr", b), 32'(rd_addr), 32'd0);
      tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    end
    tick(1, 0, 0);
    chk("resume note_valid", 32'(note_valid), 32'd1);
    chk("resume note_start", 32'(note_start), 32'd0);
    tick(1, 1, 0);
    chk("resume beat3 rd_addr", 32'(rd_addr), 32'd0);
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    tick(1, 1, 0);
    chk("resume beat4 rd_addr", 32'(rd_addr), 32'd1);
    tick(1, 0, 0);
    chk("pause gap note_valid", 32'(note_valid), 32'd1);
    tick(1, 0, 0);
    chk("pause end done", 32'(done), 32'd1);
    chk("pause end note_valid", 32'(note_valid), 32'd0);
    tick(1, 0, 0); tick(1, 1, 0);
    chk("done sticky", 32'(done), 32'd1);
    tick(1, 0, 1);
    chk("rewind from done done", 32'(done), 32'd0);
    chk("rewind from done rd_addr", 32'(rd_addr), 32'd0);

    // Rewind coincident with a completing beat at address 4
    clear_ram();
    for (int i = 0; i < 8; i++) ram[i] = mk(0, i + 1, 1);
    do_reset();
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick(1, 1, 0); tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    end
    chk("rewind pre rd_addr", 32'(rd_addr), 32'd4);
    chk("rewind pre note_out", 32'(note_out), 32'd5);
    chk("rewind pre note_valid", 32'(note_valid), 32'd1);
    tick(1, 1, 1);
    chk("rewind rd_addr", 32'(rd_addr), 32'd0);
    chk("rewind note_valid", 32'(note_valid), 32'd0);
    chk("rewind done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0);
      chk($sformatf("rewind idle%0d rd_addr", k), 32'(rd_addr), 32'd0);
      chk($sformatf("rewind idle%0d note_valid", k), 32'(note_valid), 32'd0);
    end
    tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    chk("restart note_out", 32'(note_out), 32'd1);
    chk("restart note_start", 32'(note_start), 32'd1);
    chk("restart note_valid", 32'(note_valid), 32'd1);

    // Asynchronous reset in the middle of a note
    tick(1, 1, 0); tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
    chk("mid rd_addr", 32'(rd_addr), 32'd1);
    chk("mid note_valid", 32'(note_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("async rst rd_addr", 32'(rd_addr), 32'd0);
    chk("async rst note_out", 32'(note_out), 32'd0);
    chk("async rst note_valid", 32'(note_valid), 32'd0);
    chk("async rst note_start", 32'(note_start), 32'd0);
    chk("async rst done", 32'(done), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick(0, 0, 0); tick(0, 0, 0);
    chk("post rst note_valid", 32'(note_valid), 32'd0);
    chk("post rst rd_addr", 32'(rd_addr), 32'd0);
    tick(1, 0, 0); tick(1, 0, 0);
    chk("post rst latch note_valid", 32'(note_valid), 32'd0);
    tick(1, 0, 0);
    chk("post rst note_valid", 32'(note_valid), 32'd1);
    chk("post rst note_out", 32'(note_out), 32'd1);

    // Randomized songs with ties and an end marker
    for (int s = 0; s < 3; s++) begin
      clear_ram();
      len = int'($urandom_range(5, 10));
      for (int i = 0; i < len; i++)
        ram[i] = mk(bit'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                    int'($urandom_range(1, 4)));
      do_reset();
      make_beats(len * 40 + 30);
      run_song($sformatf("rand%0d", s), len * 40 + 30);
    end

    // Every RAM entry used: stop at the top address without wrapping
    clear_ram();
    for (int i = 0; i < 128; i++) ram[i] = mk(0, i % 64, 1);
    do_reset();
    make_beats(1500);
    run_song("full", 1500);
    chk("full final done", 32'(done), 32'd1);
    chk("full final rd_addr", 32'(rd_addr), 32'd127);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_note_player
`default_nettype wire
